// File: rtl/video_pkg.sv
// Shared text-mode video geometry and the CPU-port state encoding of the VRAM arbiter.
package video_pkg;
    localparam int COLS    = 80;
    localparam int ROWS    = 30;
    localparam int CELL_H  = 16;
    localparam int H_TOTAL = 800;
    localparam int V_TOTAL = 525;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_ACK     = 2'd2,
        ST_RELEASE = 2'd3
    } cpu_state_t;
endpackage

// File: rtl/vram_fetch_addr.sv
// Display-slot detect, line select and character-cell address for the text renderer.
module vram_fetch_addr #(
    parameter int COLS   = video_pkg::COLS,
    parameter int ROWS   = video_pkg::ROWS,
    parameter int CELL_H = video_pkg::CELL_H
) (
    input  logic [9:0]  hcnt,
    input  logic [9:0]  vcnt,
    output logic        fetch,
    output logic [11:0] fetch_addr
);
    localparam logic [9:0]  H_LAST_SLOT  = 10'(video_pkg::H_TOTAL - 2);
    localparam logic [9:0]  V_LAST       = 10'(video_pkg::V_TOTAL - 1);
    localparam logic [9:0]  ACTIVE_LINES = 10'(ROWS * CELL_H);
    localparam logic [7:0]  COLS_W       = 8'(COLS);
    localparam logic [11:0] COLS_K       = 12'(COLS);
    localparam int          ROW_SHIFT    = $clog2(CELL_H);

    logic [10:0] hp2;
    logic        wrap;
    logic [7:0]  col;
    logic [9:0]  line;
    logic [9:0]  row;
    logic        slot;
    logic [11:0] row_x_cols;

    // Column 0 is fetched at the end of the previous line, hence the wrap case.
    assign hp2  = {1'b0, hcnt} + 11'd2;
    assign wrap = (hcnt == H_LAST_SLOT);
    assign col  = wrap ? 8'd0 : hp2[10:3];
    assign slot = (hp2[2:0] == 3'd0) && (col < COLS_W);
    assign line = !wrap ? vcnt : ((vcnt == V_LAST) ? 10'd0 : vcnt + 10'd1);
    assign row  = line >> ROW_SHIFT;

    always_comb begin
        row_x_cols = '0;
        for (int i = 0; i < 12; i++) begin
            if (COLS_K[i]) row_x_cols = row_x_cols + ({2'b00, row} << i);
        end
    end

    assign fetch      = slot && (line < ACTIVE_LINES);
    assign fetch_addr = row_x_cols + {4'b0000, col};
endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: display fetches always win, CPU gets free cycles via a
// four-phase request/ack handshake.
//   state      | meaning
//   ST_IDLE    | waiting for cpu_req; grants on any cycle without a display fetch
//   ST_RD_WAIT | read issued last cycle, capture mem_rdata into cpu_rdata
//   ST_ACK     | one-cycle cpu_ack pulse
//   ST_RELEASE | wait for cpu_req to drop before accepting a new request
module vram_arbiter
    import video_pkg::cpu_state_t, video_pkg::ST_IDLE, video_pkg::ST_RD_WAIT,
           video_pkg::ST_ACK, video_pkg::ST_RELEASE;
#(
    parameter int COLS   = video_pkg::COLS,
    parameter int ROWS   = video_pkg::ROWS,
    parameter int CELL_H = video_pkg::CELL_H
) (
    input  logic        pixclk,
    input  logic        n_rst,
    input  logic [9:0]  hcnt,
    input  logic [9:0]  vcnt,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [11:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_ack,
    output logic [7:0]  cpu_rdata,
    output logic [11:0] mem_addr,
    output logic        mem_we,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic [7:0]  char_code
);
    cpu_state_t  state, state_nxt;
    logic        fetch;
    logic        fetch_q;
    logic [11:0] fetch_addr;
    logic        grant;

    vram_fetch_addr #(
        .COLS   (COLS),
        .ROWS   (ROWS),
        .CELL_H (CELL_H)
    ) u_fetch_addr (
        .hcnt       (hcnt),
        .vcnt       (vcnt),
        .fetch      (fetch),
        .fetch_addr (fetch_addr)
    );

    // Memory controls are combinational, so they are gated by n_rst to read zero in reset.
    assign grant = n_rst && (state == ST_IDLE) && cpu_req && !fetch;

    always_comb begin
        state_nxt = state;
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        if (n_rst && fetch) begin
            mem_addr = fetch_addr;
        end else if (grant) begin
            mem_addr  = cpu_addr;
            mem_we    = cpu_we;
            mem_wdata = cpu_we ? cpu_wdata : 8'h00;
        end
        case (state)
            ST_IDLE:    if (grant) state_nxt = cpu_we ? ST_ACK : ST_RD_WAIT;
            ST_RD_WAIT: state_nxt = ST_ACK;
            ST_ACK:     state_nxt = ST_RELEASE;
            ST_RELEASE: if (!cpu_req) state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge pixclk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= ST_IDLE;
            fetch_q   <= 1'b0;
            char_code <= '0;
            cpu_rdata <= '0;
        end else begin
            state   <= state_nxt;
            fetch_q <= fetch;
            if (fetch_q) char_code <= mem_rdata;
            if (state == ST_RD_WAIT) cpu_rdata <= mem_rdata;
        end
    end

    assign cpu_ack = (state == ST_ACK);
endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: VRAM model, per-cycle behavioural reference and directed scenarios.
module tb_vram_arbiter;
    logic        pixclk = 1'b0;
    logic        n_rst;
    logic [9:0]  hcnt, vcnt;
    logic        cpu_req, cpu_we;
    logic [11:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_ack;
    logic [7:0]  cpu_rdata;
    logic [11:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata, mem_rdata, char_code;

    int checks   = 0;
    int failures = 0;

    logic [7:0] vram [4096];
    logic       vram_ready = 1'b0;

    vram_arbiter dut (
        .pixclk    (pixclk),
        .n_rst     (n_rst),
        .hcnt      (hcnt),
        .vcnt      (vcnt),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_ack   (cpu_ack),
        .cpu_rdata (cpu_rdata),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .char_code (char_code)
    );

    always #20 pixclk = ~pixclk;

    // Synchronous single-port VRAM, preset to addr ^ 0x5A on the first edge.
    always @(posedge pixclk) begin
        if (!vram_ready) begin
            for (int i = 0; i < 4096; i++) vram[i] <= 8'(i) ^ 8'h5A;
            vram_ready <= 1'b1;
        end else if (mem_we) begin
            vram[mem_addr] <= mem_wdata;
        end
        mem_rdata <= vram[mem_addr];
    end

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (hcnt=%0d vcnt=%0d t=%0t)",
                     nm, act, exp, hcnt, vcnt, $time);
        end
    endtask

    // Display rule: column c is fetched at hcnt = 8c-2 mod 800 on line L, if L is visible.
    function automatic void disp_expect(input int h, input int v, output bit f, output int a);
        int l;
        f = 1'b0;
        a = 0;
        for (int c = 0; c < 80; c++) begin
            if (h == (8 * c - 2 + 800) % 800) begin
                l = (h == 798) ? (v + 1) % 525 : v;
                if (l < 480) begin
                    f = 1'b1;
                    a = (l / 16) * 80 + c;
                end
            end
        end
    endfunction

    // Reference model, evaluated mid-cycle.
    int         cyc = 0;
    bit         busy = 1'b0;
    int         ack_at = -10;
    int         rd_at = -10;
    logic [7:0] rd_pend = 8'h00;
    logic [7:0] exp_rdata = 8'h00;
    logic [7:0] exp_char = 8'h00;
    logic [7:0] pend_char = 8'h00;
    bit         fetch_prev = 1'b0;

    always @(negedge pixclk) begin
        bit f;
        int fa;
        bit g;
        cyc++;
        if (!n_rst) begin
            cmp("rst_ack",   32'(cpu_ack),   32'd0);
            cmp("rst_rdata", 32'(cpu_rdata), 32'd0);
            cmp("rst_char",  32'(char_code), 32'd0);
            cmp("rst_we",    32'(mem_we),    32'd0);
            cmp("rst_addr",  32'(mem_addr),  32'd0);
            cmp("rst_wdata", 32'(mem_wdata), 32'd0);
            busy       = 1'b0;
            exp_rdata  = 8'h00;
            exp_char   = 8'h00;
            fetch_prev = 1'b0;
        end else begin
            disp_expect(int'(hcnt), int'(vcnt), f, fa);
            g = !busy && cpu_req && !f;
            cmp("ack",    32'(cpu_ack),   32'(busy && cyc == ack_at));
            cmp("rdata",  32'(cpu_rdata), 32'(exp_rdata));
            cmp("char",   32'(char_code), 32'(exp_char));
            cmp("mem_we", 32'(mem_we),    32'(g && cpu_we));
            if (f) cmp("fetch_addr", 32'(mem_addr), 32'(fa));
            if (g) cmp("grant_addr", 32'(mem_addr), 32'(cpu_addr));
            if (g && cpu_we) cmp("grant_wdata", 32'(mem_wdata), 32'(cpu_wdata));

            if (fetch_prev) exp_char = pend_char;
            fetch_prev = f;
            if (f) pend_char = vram[fa];
            if (busy && cyc == rd_at) exp_rdata = rd_pend;
            if (busy && cyc > ack_at && !cpu_req) busy = 1'b0;
            if (g) begin
                busy = 1'b1;
                if (cpu_we) begin
                    ack_at = cyc + 1;
                end else begin
                    ack_at  = cyc + 2;
                    rd_at   = cyc + 1;
                    rd_pend = vram[cpu_addr];
                end
            end
        end
    end

    task automatic tick();
        @(posedge pixclk);
        #1;
        if (hcnt == 10'd799) begin
            hcnt = 10'd0;
            vcnt = (vcnt == 10'd524) ? 10'd0 : vcnt + 10'd1;
        end else begin
            hcnt = hcnt + 10'd1;
        end
    endtask

    task automatic set_pos(input logic [9:0] h, input logic [9:0] v);
        @(posedge pixclk);
        #1;
        hcnt = h;
        vcnt = v;
    endtask

    initial begin
        int  acks;
        bit  got;
        logic [7:0] got_rdata;
        n_rst = 1'b0; hcnt = 10'd0; vcnt = 10'd0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 12'h000; cpu_wdata = 8'h00;
        repeat (3) @(posedge pixclk);
        @(negedge pixclk);
        cmp("lit_rst_char", 32'(char_code), 32'd0);

        // Line 0, hcnt 0..16: fetches for columns 1 and 2.
        set_pos(10'd0, 10'd0);
        n_rst = 1'b1;
        for (int i = 0; i < 17; i++) begin
            @(negedge pixclk);
            if (hcnt == 10'd6)  cmp("lit_fetch_c1", 32'(mem_addr), 32'd1);
            if (hcnt == 10'd14) cmp("lit_fetch_c2", 32'(mem_addr), 32'd2);
            if (hcnt == 10'd7)  cmp("lit_char_h7",  32'(char_code), 32'h00);
            if (hcnt == 10'd8)  cmp("lit_char_h8",  32'(char_code), 32'h5B);
            if (hcnt == 10'd16) cmp("lit_char_h16", 32'(char_code), 32'h58);
            tick();
        end

        // End-of-line slot fetches column 0 of the next line.
        set_pos(10'd797, 10'd16);
        tick();
        @(negedge pixclk);
        cmp("lit_fetch_row1", 32'(mem_addr), 32'd80);
        tick();
        tick();
        @(negedge pixclk);
        cmp("lit_char_row1", 32'(char_code), 32'h0A);
        set_pos(10'd798, 10'd524);
        @(negedge pixclk);
        cmp("lit_fetch_wrap", 32'(mem_addr), 32'd0);
        tick();
        tick();
        @(negedge pixclk);
        cmp("lit_char_wrap", 32'(char_code), 32'h5A);

        // Vertical blank: a write at a would-be slot is granted immediately.
        set_pos(10'd5, 10'd490);
        tick();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'hABC; cpu_wdata = 8'h3C;
        @(negedge pixclk);
        cmp("lit_vbl_we",   32'(mem_we),   32'd1);
        cmp("lit_vbl_addr", 32'(mem_addr), 32'hABC);
        cmp("lit_vbl_ack0", 32'(cpu_ack),  32'd0);
        tick();
        @(negedge pixclk);
        cmp("lit_vbl_ack1", 32'(cpu_ack),  32'd1);
        tick();
        cpu_req = 1'b0;
        repeat (2) tick();

        // Read raised on a display slot: grant 15, capture 16, ack 17.
        set_pos(10'd13, 10'd100);
        tick();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'hABC;
        @(negedge pixclk);
        cmp("lit_rd_blocked_we", 32'(mem_we),   32'd0);
        cmp("lit_rd_slot_addr",  32'(mem_addr), 32'd482);
        tick();
        @(negedge pixclk);
        cmp("lit_rd_grant_addr", 32'(mem_addr), 32'hABC);
        tick();
        cpu_addr = 12'h001; cpu_we = 1'b1;
        tick();
        @(negedge pixclk);
        cmp("lit_rd_ack",   32'(cpu_ack),   32'd1);
        cmp("lit_rd_rdata", 32'(cpu_rdata), 32'h3C);

        // Request held high after ack: no re-grant.
        acks = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            @(negedge pixclk);
            if (cpu_ack) acks++;
        end
        cmp("lit_hold_no_ack", 32'(acks), 32'd0);
        tick();
        cpu_req = 1'b0;
        tick();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h123; cpu_wdata = 8'hA5;
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge pixclk);
            if (cpu_ack) acks++;
            tick();
        end
        cmp("lit_regrant_ack", 32'(acks), 32'd1);
        cpu_req = 1'b0;
        repeat (3) tick();

        // Reset during RD_WAIT aborts the read; the held request is served afterwards.
        set_pos(10'd100, 10'd495);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h123;
        tick();
        n_rst = 1'b0;
        @(negedge pixclk);
        cmp("lit_abort_ack",   32'(cpu_ack),   32'd0);
        cmp("lit_abort_rdata", 32'(cpu_rdata), 32'd0);
        cmp("lit_abort_we",    32'(mem_we),    32'd0);
        tick();
        tick();
        n_rst = 1'b1;
        got = 1'b0;
        got_rdata = 8'h00;
        for (int i = 0; i < 8; i++) begin
            @(negedge pixclk);
            if (!got && cpu_ack) begin
                got = 1'b1;
                got_rdata = cpu_rdata;
            end
            tick();
        end
        cmp("lit_retry_ack",   32'(got),       32'd1);
        cmp("lit_retry_rdata", 32'(got_rdata), 32'hA5);
        cpu_req = 1'b0;
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
